// File: rtl/rf_nr1w.sv
// Parametrised N-read / 1-write register file with an optional zero register and write bypass.
// The storage array has no reset. A sequential clear engine zeroes it after reset or on request.
module rf_nr1w #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
  input  logic [ADDR_W-1:0]          i_wr_addr,
  input  logic [DATA_W-1:0]          i_wr_data,
  input  logic                       i_wr_en,
  input  logic                       i_clr,
  output logic                       o_busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t              state_reg;
  logic [ADDR_W:0]     cnt_reg;
  logic                busy_reg;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                wr_fire;
  logic                wr_live;

  // Control FSM. A clear request seen on the final clear cycle restarts the sweep,
  // so a held i_clr keeps o_busy high without an idle gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
      busy_reg  <= 1'b1;
    end else if (state_reg == CLEAR) begin
      if (cnt_reg == CNT_LAST) begin
        cnt_reg <= '0;
        if (!i_clr) begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end else if (i_clr) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
      busy_reg  <= 1'b1;
    end
  end

  assign o_busy  = busy_reg;
  assign wr_live = (state_reg == IDLE) && i_wr_en && !i_clr;
  assign wr_fire = wr_live && !((ZERO_REG != 0) && (i_wr_addr == '0));

  always_ff @(posedge clk) begin
    if (state_reg == CLEAR) begin
      mem[cnt_reg[ADDR_W-1:0]] <= '0;
    end else if (wr_fire) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd;

      assign ra = i_rd_addr[gi*ADDR_W +: ADDR_W];

      always_comb begin
        rd = mem[ra];
        if (busy_reg) begin
          rd = '0;
        end else if ((ZERO_REG != 0) && (ra == '0)) begin
          rd = '0;
        end else if ((BYPASS != 0) && wr_live && (ra == i_wr_addr)) begin
          rd = i_wr_data;
        end
      end

      assign o_rd_data[gi*DATA_W +: DATA_W] = rd;
    end
  endgenerate

endmodule

// File: tb/tb_rf_nr1w.sv
// Bench for rf_nr1w: default config, a no-bypass config and a small 8-bit/8-entry/4-port config.
module tb_rf_nr1w;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: defaults
  logic        rst_a, wr_en_a, clr_a, busy_a;
  logic [9:0]  rd_addr_a;
  logic [63:0] rd_data_a;
  logic [4:0]  wr_addr_a;
  logic [31:0] wr_data_a;

  // Instance B: BYPASS=0
  logic        rst_b, wr_en_b, clr_b, busy_b;
  logic [9:0]  rd_addr_b;
  logic [63:0] rd_data_b;
  logic [4:0]  wr_addr_b;
  logic [31:0] wr_data_b;

  // Instance C: DATA_W=8, ADDR_W=3, NUM_RD=4, ZERO_REG=0
  logic        rst_c, wr_en_c, clr_c, busy_c;
  logic [11:0] rd_addr_c;
  logic [31:0] rd_data_c;
  logic [2:0]  wr_addr_c;
  logic [7:0]  wr_data_c;

  rf_nr1w dut_a (
    .clk(clk), .rst_n(rst_a), .i_rd_addr(rd_addr_a), .o_rd_data(rd_data_a),
    .i_wr_addr(wr_addr_a), .i_wr_data(wr_data_a), .i_wr_en(wr_en_a),
    .i_clr(clr_a), .o_busy(busy_a)
  );

  rf_nr1w #(.BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_b), .i_rd_addr(rd_addr_b), .o_rd_data(rd_data_b),
    .i_wr_addr(wr_addr_b), .i_wr_data(wr_data_b), .i_wr_en(wr_en_b),
    .i_clr(clr_b), .o_busy(busy_b)
  );

  rf_nr1w #(.DATA_W(8), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(0)) dut_c (
    .clk(clk), .rst_n(rst_c), .i_rd_addr(rd_addr_c), .o_rd_data(rd_data_c),
    .i_wr_addr(wr_addr_c), .i_wr_data(wr_data_c), .i_wr_en(wr_en_c),
    .i_clr(clr_c), .o_busy(busy_c)
  );

  typedef struct {
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic busy_of(input int d);
    case (d)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  // Counts rising edges until o_busy drops; the final count is the edge after which it fell.
  task automatic measure(input int d, input int start, input int exp_n, input string name);
    int n;
    n = start;
    while (busy_of(d) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    $display("busy window %s: o_busy fell after edge %0d", name, n);
    chk(name, 64'(n), 64'(exp_n));
  endtask

  task automatic all_zero_a(input string name);
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = {5'(i), 5'(i)};
      #1;
      chk($sformatf("%s_%0d", name, i), rd_data_a, 64'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int gaps;

    vecs[0] = '{1'b1, 5'd7, 32'hDEADBEEF, 5'd7,  5'd7, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 5'd0, 32'h0,        5'd7,  5'd7, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd0, 32'h00001234, 5'd0,  5'd0, 32'h0,        32'h0};
    vecs[3] = '{1'b0, 5'd0, 32'h0,        5'd0,  5'd7, 32'h0,        32'hDEADBEEF};
    vecs[4] = '{1'b1, 5'd5, 32'hA5A5A5A5, 5'd3,  5'd5, 32'h0,        32'hA5A5A5A5};
    vecs[5] = '{1'b0, 5'd0, 32'h0,        5'd5,  5'd5, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[6] = '{1'b1, 5'd5, 32'h11111111, 5'd5,  5'd7, 32'h11111111, 32'hDEADBEEF};
    vecs[7] = '{1'b0, 5'd0, 32'h0,        5'd31, 5'd5, 32'h0,        32'h11111111};

    rst_a = 0; rst_b = 0; rst_c = 0;
    wr_en_a = 0; clr_a = 0; wr_addr_a = 0; wr_data_a = 0; rd_addr_a = {5'd3, 5'd7};
    wr_en_b = 0; clr_b = 0; wr_addr_b = 0; wr_data_b = 0; rd_addr_b = 0;
    wr_en_c = 0; clr_c = 0; wr_addr_c = 0; wr_data_c = 0; rd_addr_c = 12'hFFF;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy_a", 64'(busy_a), 64'd1);
    chk("rst_rd_a", rd_data_a, 64'h0);
    chk("rst_busy_c", 64'(busy_c), 64'd1);
    chk("rst_rd_c", 64'(rd_data_c), 64'h0);

    // Release A and B; a write during the clear must be dropped and reads stay 0.
    rst_a = 1; rst_b = 1;
    repeat (20) step();
    chk("busy_mid_a", 64'(busy_a), 64'd1);
    wr_en_a = 1; wr_addr_a = 5'd2; wr_data_a = 32'hFFFFFFFF; rd_addr_a = {5'd2, 5'd2};
    #2;
    chk("busy_rd_a", rd_data_a, 64'h0);
    step();
    wr_en_a = 0;
    measure(0, 21, 32, "clr_len_a_reset");
    all_zero_a("post_reset_zero");

    // Table-driven write/read/bypass vectors on A
    for (int v = 0; v < 8; v++) begin
      step();
      wr_en_a = vecs[v].wr_en; wr_addr_a = vecs[v].wr_addr; wr_data_a = vecs[v].wr_data;
      rd_addr_a = {vecs[v].ra1, vecs[v].ra0};
      #2;
      $display("vec %0d: wr_en=%0b wa=%0d wd=%h ra0=%0d rd0=%h ra1=%0d rd1=%h",
               v, vecs[v].wr_en, vecs[v].wr_addr, vecs[v].wr_data,
               vecs[v].ra0, rd_data_a[31:0], vecs[v].ra1, rd_data_a[63:32]);
      chk($sformatf("vec%0d_p0", v), 64'(rd_data_a[31:0]), 64'(vecs[v].e0));
      chk($sformatf("vec%0d_p1", v), 64'(rd_data_a[63:32]), 64'(vecs[v].e1));
    end
    step();
    wr_en_a = 0;

    // No bypass: old value in the write cycle, new value one cycle later
    wr_en_b = 1; wr_addr_b = 5'd5; wr_data_b = 32'hA5A5A5A5; rd_addr_b = {5'd5, 5'd0};
    #2;
    chk("nobyp_same_1", 64'(rd_data_b[63:32]), 64'h0);
    step();
    wr_en_b = 0;
    #2;
    chk("nobyp_next_1", 64'(rd_data_b[63:32]), 64'hA5A5A5A5);
    step();
    wr_en_b = 1; wr_data_b = 32'h12345678; rd_addr_b = {5'd5, 5'd5};
    #2;
    chk("nobyp_same_2", rd_data_b, {32'hA5A5A5A5, 32'hA5A5A5A5});
    step();
    wr_en_b = 0;
    #2;
    chk("nobyp_next_2", rd_data_b, {32'h12345678, 32'h12345678});

    // Fill A with addr*3, then clear request colliding with a write to addr 9
    for (int a = 1; a < 32; a++) begin
      step();
      wr_en_a = 1; wr_addr_a = 5'(a); wr_data_a = 32'(a * 3);
    end
    step();
    wr_en_a = 0; rd_addr_a = {5'd31, 5'd9};
    #2;
    chk("fill_rd", rd_data_a, {32'd93, 32'd27});
    step();
    clr_a = 1; wr_en_a = 1; wr_addr_a = 5'd9; wr_data_a = 32'h00000BAD; rd_addr_a = {5'd9, 5'd9};
    #2;
    chk("clr_req_busy_pre", 64'(busy_a), 64'd0);
    chk("clr_req_no_bypass", 64'(rd_data_a[31:0]), 64'd27);
    step();
    clr_a = 0; wr_en_a = 0;
    measure(0, 1, 33, "clr_len_a_req");
    all_zero_a("post_clr_zero");

    // Held clear request: no idle gap, last sweep completes after release
    step();
    clr_a = 1;
    gaps = 0;
    for (int i = 0; i < 70; i++) begin
      step();
      if (!busy_a) gaps++;
    end
    clr_a = 0;
    chk("held_clr_gaps", 64'(gaps), 64'd0);
    measure(0, 70, 97, "clr_len_a_held");

    // Reset asserted mid-clear restarts the full sweep
    step();
    clr_a = 1;
    step();
    clr_a = 0;
    repeat (10) step();
    chk("midclr_busy_a", 64'(busy_a), 64'd1);
    rst_a = 0; rd_addr_a = {5'd31, 5'd9};
    #1;
    chk("midclr_rst_busy_a", 64'(busy_a), 64'd1);
    chk("midclr_rst_rd_a", rd_data_a, 64'h0);
    step();
    rst_a = 1;
    measure(0, 0, 32, "clr_len_a_midrst");

    // Small config: 8-entry clear, mid-clear reset, writable entry 0
    rst_c = 1;
    measure(2, 0, 8, "clr_len_c_reset");
    step();
    clr_c = 1;
    step();
    clr_c = 0;
    repeat (3) step();
    rst_c = 0;
    #1;
    chk("midclr_rst_busy_c", 64'(busy_c), 64'd1);
    step();
    rst_c = 1;
    measure(2, 0, 8, "clr_len_c_midrst");
    step();
    wr_en_c = 1; wr_addr_c = 3'd0; wr_data_c = 8'h5C; rd_addr_c = 12'h000;
    #2;
    chk("c_bypass_addr0", 64'(rd_data_c), 64'h5C5C5C5C);
    step();
    wr_en_c = 1; wr_addr_c = 3'd7; wr_data_c = 8'h81;
    #2;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("c_addr0_p%0d", k), 64'(rd_data_c[k*8 +: 8]), 64'h5C);
    end
    step();
    wr_en_c = 0; rd_addr_c = {3'd0, 3'd7, 3'd3, 3'd7};
    #2;
    $display("c read: ports {0,7,3,7} -> %h", rd_data_c);
    chk("c_mixed_ports", 64'(rd_data_c), 64'h5C810081);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
